button_pulse_conditioner: RTL and testbench
===========================================

Name: button_pulse_conditioner

Overview:
- Upstream front end for the duty-cycle stage.
- Takes the raw asynchronous increase/decrease button levels and synchronises and debounces each one.
- Emits single-cycle inc_pulse/dec_pulse strobes, one step per press, with optional auto-repeat while a button is held.
- The downstream PWM stage increments or decrements DUTY_CYCLE once per strobe.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised level must hold before it is accepted (10 ms at 100 MHz); legal range ≥2.
- REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first repeat pulse (500 ms); legal range ≥2.
- REPEAT_PERIOD, 25000000, cycles between subsequent repeat pulses (250 ms); legal range ≥2.

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock, no other clock domains.
- increase_btn  input  1  raw increase button, asynchronous, bouncy.
- decrease_btn  input  1  raw decrease button, asynchronous, bouncy.
- repeat_en  input  1  1 = auto-repeat while held; 0 = exactly one pulse per press.
- inc_pulse  output  1  one-cycle strobe: step duty up.
- dec_pulse  output  1  one-cycle strobe: step duty down.
- inc_level  output  1  debounced increase level.
- dec_level  output  1  debounced decrease level.

Behaviour:
- Reset: on rst_n low (async), all registers clear, including the synchronisers, debounce counters, stable levels, FSMs, timers and all outputs. All outputs are 0 and remain 0 while rst_n is low. Release is synchronous to clk.
- Synchroniser: two flops per button (s1, s2); s2 is the only signal used downstream.
- Debounce, per button:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any bounce back to the stable value restarts the count.
- inc_level/dec_level equal the respective stable registers.
- Press latency: with a clean raw input first sampled high at edge 1, stable rises at edge D+2 (D = DEBOUNCE_CYCLES) and the registered pulse is high after edge D+3 for exactly one cycle. Release latency is symmetric, with no pulse on release.
- Per-button FSM states are IDLE, HOLD, REPEAT. The timer width is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE: on stable 0->1, raise the press pulse, clear the timer, go to HOLD.
  - HOLD: the timer counts. When timer == REPEAT_DELAY-1 and repeat_en=1: raise the pulse, clear the timer, go to REPEAT. If repeat_en=0, stay in HOLD and the timer saturates.
  - REPEAT: when timer == REPEAT_PERIOD-1, raise the pulse and clear the timer. If repeat_en drops, go to HOLD with the timer saturated, so no further pulses.
  - From any state, stable falling to 0 goes to IDLE and clears the timer that same cycle; no pulse is generated on that cycle.
- Conflict rule:
  - While both stable levels are 1, both inc_pulse and dec_pulse are forced to 0, including any press or repeat pulse that would fall in that window; the FSMs still advance.
  - If one button is released, the remaining button's FSM continues from its current state/timer; its next scheduled repeat pulse is emitted normally.
- Pulse guarantees:
  - Pulses are never wider than one cycle.
  - inc_pulse and dec_pulse are never both 1 in the same cycle.
- Reset mid-operation: everything clears. If a button is still held after reset release, it re-debounces and produces a fresh press pulse at edge D+3 after release.
- Counters never wrap: parameters bound all compares.

Test Plan:
1. D=4, DELAY=10, PERIOD=5, repeat_en=0. Hold increase_btn from edge 1 for 40 cycles -> inc_pulse high only after edge 7, one cycle; inc_level high from edge 6. Release -> inc_level falls 6 edges after the last high sample; no further pulses.
2. Same parameters, increase_btn toggling every 2 cycles for 20 cycles, then held -> no pulse during the toggling. Exactly one inc_pulse D+3 edges after the final rising edge.
3. repeat_en=1, hold decrease_btn 40 cycles -> dec_pulse after edges 7, 17, 22, 27, 32, 37…; the first gap is 10, later gaps are 5. Release -> pulses stop.
4. Hold increase, then press decrease 3 cycles later while increase is held -> no pulses while both levels are 1. Release decrease -> inc_pulse resumes on its original repeat schedule; never both strobes in one cycle.
5. Hold increase with repeat_en=1, assert rst_n low for 3 cycles at cycle 20 -> all outputs 0 immediately (async). After release with the button still held -> a new inc_pulse D+3 edges later.
6. repeat_en toggled 1->0 while in REPEAT -> no further pulses for the remainder of the hold. Re-press after release -> a single press pulse.

Source files
------------

// File: rtl/button_pulse_conditioner.sv
// Button front end: per-button two-flop synchroniser, debounce filter and
// press/auto-repeat FSM, with a conflict mask when both buttons are held.

module button_pulse_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  input  logic other_stable,
  output logic level,
  output logic pulse
);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic          s1, s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  state_t        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Any return of s2 to the accepted value restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A pulse scheduled while the other button is also accepted is dropped,
  // but the state/timer advance exactly as if it had been emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!stable) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            pulse <= !other_stable;
            timer <= '0;
            state <= HOLD;
          end
          HOLD: begin
            if (timer == DELAY_LAST) begin
              if (repeat_en) begin
                pulse <= !other_stable;
                timer <= '0;
                state <= REPEAT;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          REPEAT: begin
            if (!repeat_en) begin
              state <= HOLD;
              timer <= DELAY_LAST;
            end else if (timer == PERIOD_LAST) begin
              pulse <= !other_stable;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign level = stable;
endmodule

module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic increase_btn,
  input  logic decrease_btn,
  input  logic repeat_en,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);
  logic inc_pulse_q, dec_pulse_q;
  logic both_held;

  button_pulse_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_inc (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (increase_btn),
    .repeat_en   (repeat_en),
    .other_stable(dec_level),
    .level       (inc_level),
    .pulse       (inc_pulse_q)
  );

  button_pulse_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dec (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (decrease_btn),
    .repeat_en   (repeat_en),
    .other_stable(inc_level),
    .level       (dec_level),
    .pulse       (dec_pulse_q)
  );

  // Also gate on the visible levels so no strobe appears in a both-held cycle.
  assign both_held = inc_level & dec_level;
  assign inc_pulse = inc_pulse_q & ~both_held;
  assign dec_pulse = dec_pulse_q & ~both_held;
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with small timing parameters;
// expected strobes are queued per test and matched by a negedge monitor.

module tb_button_pulse_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic increase_btn = 1'b0;
  logic decrease_btn = 1'b0;
  logic repeat_en = 1'b0;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  int cyc = 0;
  int t0 = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .increase_btn(increase_btn),
    .decrease_btn(decrease_btn),
    .repeat_en   (repeat_en),
    .inc_pulse   (inc_pulse),
    .dec_pulse   (dec_pulse),
    .inc_level   (inc_level),
    .dec_level   (dec_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entry encoding: bit 31 = dec strobe, bits 30:0 = absolute cycle stamp.
  task automatic expect_pulse(input bit is_dec, input int t);
    exp_q.push_back({is_dec, 31'(t0 + t)});
  endtask

  task automatic start_test();
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic at(input int t);
    while (cyc < t0 + t) @(negedge clk);
  endtask

  task automatic end_test(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (inc_pulse || dec_pulse) begin
      check("strobe_exclusive", 32'(inc_pulse & dec_pulse), 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: inc=%0b dec=%0b at cycle %0d, none expected",
                 inc_pulse, dec_pulse, cyc - t0);
      end else begin
        check("pulse_stamp", {dec_pulse, 31'(cyc)}, exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_inc_pulse", 32'(inc_pulse), 32'd0);
    check("rst_dec_pulse", 32'(dec_pulse), 32'd0);
    check("rst_inc_level", 32'(inc_level), 32'd0);
    check("rst_dec_level", 32'(dec_level), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single press, no repeat
    start_test();
    repeat_en = 1'b0;
    increase_btn = 1'b1;
    expect_pulse(1'b0, 7);
    at(5);  check("t1_level_pre", 32'(inc_level), 32'd0);
    at(6);  check("t1_level_up", 32'(inc_level), 32'd1);
    at(40); increase_btn = 1'b0;
    at(45); check("t1_level_hold", 32'(inc_level), 32'd1);
    at(46); check("t1_level_down", 32'(inc_level), 32'd0);
    at(60); end_test("t1_queue_empty");

    // 2: bouncing input, then a clean hold
    start_test();
    for (int t = 0; t <= 20; t += 2) begin
      at(t);
      increase_btn = ((t / 2) % 2 == 0);
    end
    expect_pulse(1'b0, 27);
    at(25); check("t2_level_pre", 32'(inc_level), 32'd0);
    at(26); check("t2_level_up", 32'(inc_level), 32'd1);
    at(40); increase_btn = 1'b0;
    at(60); end_test("t2_queue_empty");

    // 3: auto-repeat on decrease
    start_test();
    repeat_en = 1'b1;
    decrease_btn = 1'b1;
    expect_pulse(1'b1, 7);
    for (int t = 17; t <= 42; t += 5) expect_pulse(1'b1, t);
    at(40); decrease_btn = 1'b0;
    at(46); check("t3_level_down", 32'(dec_level), 32'd0);
    at(60); end_test("t3_queue_empty");

    // 4: both held masks strobes; increase keeps its repeat schedule
    start_test();
    repeat_en = 1'b1;
    increase_btn = 1'b1;
    expect_pulse(1'b0, 7);
    expect_pulse(1'b0, 27);
    expect_pulse(1'b0, 32);
    expect_pulse(1'b0, 37);
    expect_pulse(1'b0, 42);
    at(3);  decrease_btn = 1'b1;
    at(12); check("t4_both_levels", {30'd0, inc_level, dec_level}, 32'd3);
    at(20); decrease_btn = 1'b0;
    at(26); check("t4_dec_down", 32'(dec_level), 32'd0);
    at(40); increase_btn = 1'b0;
    at(60); end_test("t4_queue_empty");

    // 5: reset in the middle of a hold
    start_test();
    repeat_en = 1'b1;
    increase_btn = 1'b1;
    expect_pulse(1'b0, 7);
    expect_pulse(1'b0, 17);
    at(20);
    rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(inc_level), 32'd0);
    check("t5_async_pulses", {30'd0, inc_pulse, dec_pulse}, 32'd0);
    at(23); rst_n = 1'b1;
    expect_pulse(1'b0, 30);
    expect_pulse(1'b0, 40);
    expect_pulse(1'b0, 45);
    expect_pulse(1'b0, 50);
    at(28); check("t5_relevel_pre", 32'(inc_level), 32'd0);
    at(29); check("t5_relevel_up", 32'(inc_level), 32'd1);
    at(45); increase_btn = 1'b0;
    at(70); end_test("t5_queue_empty");

    // 6: repeat disabled mid-repeat, then a re-press
    start_test();
    repeat_en = 1'b1;
    increase_btn = 1'b1;
    expect_pulse(1'b0, 7);
    expect_pulse(1'b0, 17);
    expect_pulse(1'b0, 22);
    expect_pulse(1'b0, 57);
    at(23);  repeat_en = 1'b0;
    at(40);  increase_btn = 1'b0;
    at(50);  increase_btn = 1'b1;
    at(80);  increase_btn = 1'b0;
    at(100); end_test("t6_queue_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
